// File: rtl/oven_timer_ctrl_pkg.sv
// Shared definitions for the oven cook-time controller: state encoding,
// thermostat defaults, minute limits and the saturating minute increment.
package oven_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } oven_state_t;

  localparam int         MAX_MIN_DEF  = 99;
  localparam logic [7:0] SETPOINT_DEF = 8'd180;
  localparam logic [7:0] HYST_DEF     = 8'd5;

  localparam int MIN_W = 7;
  localparam int SEC_W = 6;

  // Add one minute, pinned at the configured limit.
  function automatic logic [MIN_W-1:0] min_sat_inc(input logic [MIN_W-1:0] m,
                                                   input logic [MIN_W-1:0] lim);
    return (m >= lim) ? lim : m + 1'b1;
  endfunction

endpackage

// File: rtl/oven_timer_ctrl_btn_cond.sv
// Front-panel button conditioner: two-flop synchroniser, stability counter
// and a one-cycle pulse on the accepted press (debounced 0->1).
module oven_timer_ctrl_btn_cond #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int             CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw contact into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYC cycles in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_pulse <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/oven_timer_ctrl.sv
// Oven cook-time controller: minutes/seconds countdown with pause, end-of-cook
// buzzer, and a hysteresis thermostat gating the heater while running.
module oven_timer_ctrl
  import oven_timer_ctrl_pkg::*;
#(
  parameter int         CLK_DIV      = 50000000,
  parameter int         DEBOUNCE_CYC = 500000,
  parameter int         MAX_MIN      = MAX_MIN_DEF,
  parameter logic [7:0] SETPOINT     = SETPOINT_DEF,
  parameter logic [7:0] HYST         = HYST_DEF,
  parameter int         BUZZ_SEC     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_add,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic [7:0] temp,
  output logic [7:0] digit_time,
  output logic       running,
  output logic       heat_on,
  output logic       buzzer
);

  localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam int               BUZ_W    = (BUZZ_SEC > 1) ? $clog2(BUZZ_SEC) : 1;
  localparam logic [BUZ_W-1:0] BUZ_LAST = BUZ_W'(BUZZ_SEC - 1);
  localparam logic [MIN_W-1:0] MIN_LIM  = MIN_W'(MAX_MIN);
  localparam logic [7:0]       REARM    = SETPOINT - HYST;

  oven_state_t      r_state;
  logic [MIN_W-1:0] r_min;
  logic [SEC_W-1:0] r_sec;
  logic [PRE_W-1:0] r_pre;
  logic [BUZ_W-1:0] r_buzz;
  logic             r_flag;
  logic             r_running;
  logic             r_heat;
  logic             r_buzzer;

  logic             w_add;
  logic             w_start;
  logic             w_clr;
  logic             w_tick;
  logic             w_flag_nxt;
  logic [MIN_W-1:0] w_min_inc;

  oven_timer_ctrl_btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_add (
    .clk(clk), .rst(rst), .i_btn(btn_add), .o_pulse(w_add)
  );
  oven_timer_ctrl_btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_start (
    .clk(clk), .rst(rst), .i_btn(btn_start), .o_pulse(w_start)
  );
  oven_timer_ctrl_btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_clear (
    .clk(clk), .rst(rst), .i_btn(btn_clear), .o_pulse(w_clr)
  );

  // One-second tick only exists while the prescaler is live (RUN and DONE).
  assign w_tick     = ((r_state == ST_RUN) || (r_state == ST_DONE)) && (r_pre == PRE_LAST);
  assign w_min_inc  = min_sat_inc(r_min, MIN_LIM);
  assign w_flag_nxt = (temp >= SETPOINT) ? 1'b0 :
                      (temp <= REARM)    ? 1'b1 : r_flag;

  // Thermostat hysteresis flag, tracked in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_flag <= 1'b1;
    else     r_flag <= w_flag_nxt;
  end

  // Cook FSM: clear > start > add; counters and outputs move with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_min     <= '0;
      r_sec     <= '0;
      r_pre     <= '0;
      r_buzz    <= '0;
      r_running <= 1'b0;
      r_heat    <= 1'b0;
      r_buzzer  <= 1'b0;
    end else begin
      r_heat <= r_running & w_flag_nxt;
      if (w_clr) begin
        r_state   <= ST_IDLE;
        r_min     <= '0;
        r_sec     <= '0;
        r_pre     <= '0;
        r_buzz    <= '0;
        r_running <= 1'b0;
        r_heat    <= 1'b0;
        r_buzzer  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              if (r_min != '0) begin
                r_state   <= ST_RUN;
                r_sec     <= '0;
                r_pre     <= '0;
                r_running <= 1'b1;
                r_heat    <= w_flag_nxt;
              end
            end else if (w_add) begin
              r_min <= w_min_inc;
            end
          end
          ST_RUN: begin
            if (w_start) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
              r_heat    <= 1'b0;
            end else begin
              r_pre <= w_tick ? '0 : r_pre + 1'b1;
              if (w_tick && (r_sec != '0)) begin
                r_sec <= r_sec - 1'b1;
                if (w_add) r_min <= w_min_inc;
              end else if (w_tick && (r_min != '0)) begin
                r_sec <= SEC_W'(59);
                r_min <= w_add ? r_min : r_min - 1'b1;
              end else if (w_tick) begin
                r_state   <= ST_DONE;
                r_buzz    <= '0;
                r_running <= 1'b0;
                r_heat    <= 1'b0;
                r_buzzer  <= 1'b1;
              end else if (w_add) begin
                r_min <= w_min_inc;
              end
            end
          end
          ST_PAUSE: begin
            if (w_start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
              r_heat    <= w_flag_nxt;
            end else if (w_add) begin
              r_min <= w_min_inc;
            end
          end
          ST_DONE: begin
            if (w_add || w_start) begin
              r_state  <= ST_IDLE;
              r_pre    <= '0;
              r_buzz   <= '0;
              r_buzzer <= 1'b0;
            end else begin
              r_pre <= w_tick ? '0 : r_pre + 1'b1;
              if (w_tick) begin
                if (r_buzz == BUZ_LAST) begin
                  r_state  <= ST_IDLE;
                  r_buzz   <= '0;
                  r_buzzer <= 1'b0;
                end else begin
                  r_buzz <= r_buzz + 1'b1;
                end
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign digit_time = {1'b0, r_min};
  assign running    = r_running;
  assign heat_on    = r_heat;
  assign buzzer     = r_buzzer;

endmodule

// File: tb/tb_oven_timer_ctrl.sv
// Directed bench for oven_timer_ctrl with CLK_DIV=4, DEBOUNCE_CYC=2, BUZZ_SEC=2.
module tb_oven_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_add = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic [7:0] temp = 8'd170;
  logic [7:0] digit_time;
  logic       running;
  logic       heat_on;
  logic       buzzer;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_s, t_p, t_r, t_d;

  oven_timer_ctrl #(
    .CLK_DIV(4), .DEBOUNCE_CYC(2), .MAX_MIN(99),
    .SETPOINT(8'd180), .HYST(8'd5), .BUZZ_SEC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_add(btn_add), .btn_start(btn_start), .btn_clear(btn_clear),
    .temp(temp), .digit_time(digit_time),
    .running(running), .heat_on(heat_on), .buzzer(buzzer)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_add   = v;
      1:       btn_start = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge clk);
    set_btn(b, 1'b1);
    tick_n(6);
    set_btn(b, 1'b0);
    tick_n(6);
  endtask

  // Bounded wait for running to reach v; returns the cycle it was seen.
  task automatic wait_run(input logic v, input string tag, output int t);
    int k;
    k = 0;
    while (running !== v && k < 40) begin
      @(negedge clk);
      k++;
    end
    t = cyc;
    chk(tag, int'(running === v), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // reset state
    tick_n(2);
    chk("rst_digit", digit_time, 0);
    chk("rst_running", running, 0);
    chk("rst_heat", heat_on, 0);
    chk("rst_buzzer", buzzer, 0);
    rst = 1'b0;
    tick_n(2);

    // bounce rejection then one clean hold
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); btn_add = 1'b1;
      @(negedge clk); btn_add = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); btn_add = 1'b1;
      @(negedge clk); btn_add = 1'b0;
    end
    tick_n(10);
    chk("bounce_glitch", digit_time, 0);
    @(negedge clk); btn_add = 1'b1;
    tick_n(5); btn_add = 1'b0;
    tick_n(10);
    chk("bounce_hold", digit_time, 1);

    // three minutes end to end
    press(0); press(0);
    chk("add3", digit_time, 3);
    @(negedge clk); btn_start = 1'b1;
    wait_run(1'b1, "run3_start", t_s);
    btn_start = 1'b0;
    chk("run3_digit", digit_time, 3);
    go_to(t_s + 3);   chk("run3_pre_tick1", digit_time, 3);
    go_to(t_s + 4);   chk("run3_tick1", digit_time, 2);
    go_to(t_s + 243); chk("run3_tick60", digit_time, 2);
    go_to(t_s + 244); chk("run3_tick61", digit_time, 1);
    go_to(t_s + 723); chk("run3_pre_done_buz", buzzer, 0);
    chk("run3_pre_done_run", running, 1);
    go_to(t_s + 724); chk("run3_done_buz", buzzer, 1);
    chk("run3_done_run", running, 0);
    chk("run3_done_digit", digit_time, 0);
    go_to(t_s + 731); chk("run3_buz_hold", buzzer, 1);
    go_to(t_s + 732); chk("run3_buz_off", buzzer, 0);
    chk("run3_idle_run", running, 0);
    tick_n(4);

    // saturation at 99
    for (int i = 0; i < 98; i++) press(0);
    chk("sat_98", digit_time, 98);
    press(0);
    chk("sat_99", digit_time, 99);
    for (int i = 0; i < 21; i++) press(0);
    chk("sat_120", digit_time, 99);
    press(2);
    chk("sat_clear", digit_time, 0);

    // start beats add; start with zero minutes does nothing
    @(negedge clk); btn_add = 1'b1; btn_start = 1'b1;
    tick_n(6); btn_add = 1'b0; btn_start = 1'b0;
    tick_n(6);
    chk("start_over_add_digit", digit_time, 0);
    chk("start_over_add_run", running, 0);

    // pause holds the prescaler: DONE lands after 244 running prescaler steps
    press(0);
    @(negedge clk); btn_start = 1'b1;
    wait_run(1'b1, "pz_start", t_s);
    btn_start = 1'b0;
    tick_n(4);
    @(negedge clk); btn_start = 1'b1;
    wait_run(1'b0, "pz_pause", t_p);
    btn_start = 1'b0;
    tick_n(50);
    chk("pz_hold_run", running, 0);
    chk("pz_hold_digit", digit_time, 0);
    @(negedge clk); btn_start = 1'b1;
    wait_run(1'b1, "pz_resume", t_r);
    btn_start = 1'b0;
    t_d = t_r + 244 - (t_p - t_s - 1);
    go_to(t_d - 1); chk("pz_pre_done_buz", buzzer, 0);
    chk("pz_pre_done_run", running, 1);
    go_to(t_d);     chk("pz_done_buz", buzzer, 1);

    // any button in DONE returns to IDLE early without its own action
    btn_add = 1'b1;
    go_to(t_d + 6);
    chk("done_btn_buz", buzzer, 0);
    chk("done_btn_run", running, 0);
    btn_add = 1'b0;
    tick_n(10);
    chk("done_btn_digit", digit_time, 0);

    // start and clear in the same cycle while running
    press(0); press(0);
    @(negedge clk); btn_start = 1'b1;
    wait_run(1'b1, "sc_start", t_s);
    btn_start = 1'b0;
    tick_n(6);
    @(negedge clk); btn_start = 1'b1; btn_clear = 1'b1;
    tick_n(6); btn_start = 1'b0; btn_clear = 1'b0;
    tick_n(6);
    chk("sc_run", running, 0);
    chk("sc_digit", digit_time, 0);

    // thermostat while running, across pause, then async reset mid-run
    for (int i = 0; i < 5; i++) press(0);
    @(negedge clk); btn_start = 1'b1;
    wait_run(1'b1, "th_start", t_s);
    btn_start = 1'b0;
    chk("th_170", heat_on, 1);
    temp = 8'd180; tick_n(2); chk("th_180", heat_on, 0);
    temp = 8'd177; tick_n(2); chk("th_177", heat_on, 0);
    temp = 8'd175; tick_n(2); chk("th_175", heat_on, 1);
    tick_n(2);
    @(negedge clk); btn_start = 1'b1;
    wait_run(1'b0, "th_pause", t_p);
    btn_start = 1'b0;
    chk("th_pause_heat", heat_on, 0);
    tick_n(4);
    temp = 8'd182; tick_n(3);
    temp = 8'd178; tick_n(3);
    @(negedge clk); btn_start = 1'b1;
    wait_run(1'b1, "th_resume", t_r);
    btn_start = 1'b0;
    chk("th_resume_heat", heat_on, 0);
    temp = 8'd175; tick_n(2); chk("th_rearm", heat_on, 1);
    chk("arst_pre_digit", digit_time, 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_digit", digit_time, 0);
    chk("arst_running", running, 0);
    chk("arst_heat", heat_on, 0);
    chk("arst_buzzer", buzzer, 0);
    @(negedge clk); rst = 1'b0;
    tick_n(8);
    chk("arst_after_run", running, 0);
    chk("arst_after_heat", heat_on, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
